secure_scan_gate_n: RTL and testbench

Parametrised, multi-channel successor to the single-chain PUF-gated scan enable in the secure SiP test path. The block authenticates a host-supplied response against the die's PUF response and opens a bounded test window of a programmed cycle count on a selected subset of `NUM_CH` scan chains. Failed attempts are counted, and repeated failure forces a timed lockout. It sits between the JTAG-side secure data registers and the per-chain scan muxes, clocked by TCK.

---
 rtl/secure_scan_gate_n.sv | 149 ++++++++++++++
 tb/tb_secure_scan_gate_n.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/secure_scan_gate_n.sv
// secure_scan_gate_n: PUF-authenticated, multi-chain scan window gate.
// A request is checked against the die's PUF response. A pass opens a
// bounded window on the requested chains. Repeated mismatches force a
// timed lockout.
module secure_scan_gate_n #(
  parameter int NUM_CH      = 4,
  parameter int KEY_W       = 16,
  parameter int CNT_W       = 16,
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 64,
  localparam int FW         = $clog2(MAX_FAIL+1)
) (
  input  logic              TCK,
  input  logic              TRST_N,
  input  logic              auth_req,
  input  logic [KEY_W-1:0]  auth_resp,
  input  logic [KEY_W-1:0]  puf_resp,
  input  logic              puf_ready,
  input  logic [CNT_W-1:0]  window_len,
  input  logic [NUM_CH-1:0] ch_req,
  input  logic              relock,
  input  logic [NUM_CH-1:0] scan_si,
  input  logic [NUM_CH-1:0] chain_so,
  output logic [NUM_CH-1:0] chain_si,
  output logic [NUM_CH-1:0] scan_so,
  output logic [NUM_CH-1:0] scan_enable,
  output logic              window_open,
  output logic              locked,
  output logic              auth_busy,
  output logic              auth_done,
  output logic [1:0]        auth_status,
  output logic [CNT_W-1:0]  remaining,
  output logic [FW-1:0]     fail_count
);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_OPEN, S_LOCK} state_t;

  localparam logic [FW-1:0]    FAIL_MAX  = FW'(MAX_FAIL);
  localparam logic [FW-1:0]    FAIL_LAST = FW'(MAX_FAIL-1);
  localparam logic [CNT_W-1:0] LOCK_LD   = CNT_W'(LOCK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [1:0] ST_PASS = 2'b00;
  localparam logic [1:0] ST_MISM = 2'b01;
  localparam logic [1:0] ST_INV  = 2'b10;
  localparam logic [1:0] ST_LOCK = 2'b11;

  state_t            state_q;
  logic [KEY_W-1:0]  resp_q, puf_q;
  logic              rdy_q;
  logic [NUM_CH-1:0] mask_q, en_q;
  logic [CNT_W-1:0]  len_q, rem_q;
  logic [FW-1:0]     fail_q;
  logic              done_q;
  logic [1:0]        status_q;

  // Auth FSM: all outputs are registered here; counters load on state entry.
  always_ff @(posedge TCK) begin
    if (!TRST_N) begin
      state_q  <= S_IDLE;
      resp_q   <= '0;
      puf_q    <= '0;
      rdy_q    <= 1'b0;
      mask_q   <= '0;
      len_q    <= '0;
      en_q     <= '0;
      rem_q    <= '0;
      fail_q   <= '0;
      done_q   <= 1'b0;
      status_q <= ST_PASS;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (auth_req) begin
            state_q <= S_CHECK;
            resp_q  <= auth_resp;
            puf_q   <= puf_resp;
            rdy_q   <= puf_ready;
            mask_q  <= ch_req;
            len_q   <= window_len;
          end
        end
        S_CHECK: begin
          done_q <= 1'b1;
          if (!rdy_q || mask_q == '0 || len_q == '0) begin
            status_q <= ST_INV;
            state_q  <= S_IDLE;
          end else if (resp_q != puf_q) begin
            status_q <= ST_MISM;
            if (fail_q >= FAIL_LAST) begin
              // Saturate at the limit and start the lockout timer.
              fail_q  <= FAIL_MAX;
              rem_q   <= LOCK_LD;
              state_q <= S_LOCK;
            end else begin
              fail_q  <= fail_q + FW'(1);
              state_q <= S_IDLE;
            end
          end else begin
            status_q <= ST_PASS;
            fail_q   <= '0;
            rem_q    <= len_q;
            en_q     <= mask_q;
            state_q  <= S_OPEN;
          end
        end
        S_OPEN: begin
          // <= 1 rather than == 1 so a zero count can never stall the window.
          if (relock || rem_q <= CNT_ONE) begin
            en_q    <= '0;
            rem_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            rem_q <= rem_q - CNT_ONE;
          end
        end
        S_LOCK: begin
          if (rem_q <= CNT_ONE) begin
            rem_q   <= '0;
            fail_q  <= '0;
            state_q <= S_IDLE;
          end else begin
            rem_q <= rem_q - CNT_ONE;
            // Refuse requests with a status; skip if a pulse is already out
            // so auth_done never stays high two cycles running.
            if (auth_req && !done_q) begin
              done_q   <= 1'b1;
              status_q <= ST_LOCK;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign scan_enable = en_q;
  assign chain_si    = scan_si & en_q;
  assign scan_so     = chain_so & en_q;
  assign window_open = (state_q == S_OPEN);
  assign locked      = (state_q == S_LOCK);
  assign auth_busy   = (state_q == S_CHECK);
  assign auth_done   = done_q;
  assign auth_status = status_q;
  assign remaining   = rem_q;
  assign fail_count  = fail_q;

endmodule

// File: tb/tb_secure_scan_gate_n.sv
// tb_secure_scan_gate_n: scoreboard bench; every request pushes its expected
// result, and a negedge monitor pops and checks it on each auth_done pulse.
module tb_secure_scan_gate_n;

  localparam int NUM_CH = 4;
  localparam int KEY_W  = 16;
  localparam int CNT_W  = 16;
  localparam int MAXF   = 3;
  localparam int LOCKC  = 64;
  localparam logic [KEY_W-1:0] PUF = 16'hA5C3;
  localparam logic [KEY_W-1:0] BAD = 16'h1234;

  logic              TCK = 1'b0;
  logic              TRST_N;
  logic              auth_req;
  logic [KEY_W-1:0]  auth_resp, puf_resp;
  logic              puf_ready;
  logic [CNT_W-1:0]  window_len;
  logic [NUM_CH-1:0] ch_req;
  logic              relock;
  logic [NUM_CH-1:0] scan_si, chain_so;
  logic [NUM_CH-1:0] chain_si, scan_so, scan_enable;
  logic              window_open, locked, auth_busy, auth_done;
  logic [1:0]        auth_status;
  logic [CNT_W-1:0]  remaining;
  logic [1:0]        fail_count;

  secure_scan_gate_n #(.NUM_CH(NUM_CH), .KEY_W(KEY_W), .CNT_W(CNT_W),
                       .MAX_FAIL(MAXF), .LOCK_CYCLES(LOCKC)) dut (
    .TCK(TCK), .TRST_N(TRST_N), .auth_req(auth_req), .auth_resp(auth_resp),
    .puf_resp(puf_resp), .puf_ready(puf_ready), .window_len(window_len),
    .ch_req(ch_req), .relock(relock), .scan_si(scan_si), .chain_so(chain_so),
    .chain_si(chain_si), .scan_so(scan_so), .scan_enable(scan_enable),
    .window_open(window_open), .locked(locked), .auth_busy(auth_busy),
    .auth_done(auth_done), .auth_status(auth_status), .remaining(remaining),
    .fail_count(fail_count));

  always #5 TCK = ~TCK;

  typedef struct packed { logic [1:0] st; logic [1:0] fc; } exp_t;
  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   mfail  = 0;
  logic prev_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: compare every result pulse with the oldest expectation.
  always @(negedge TCK) begin
    if (auth_done === 1'b1) begin
      chk("done_consec", {31'd0, prev_done}, 32'd0);
      if (sbq.size() == 0) chk("spurious_done", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sbq.pop_front();
        chk("status", {30'd0, auth_status}, {30'd0, e.st});
        chk("fail_cnt", {30'd0, fail_count}, {30'd0, e.fc});
      end
    end
    prev_done = (auth_done === 1'b1);
  end

  // Drive one request right after a rising edge; model its expected result.
  // Returns just after the edge on which the result is registered.
  task automatic do_req(input logic [KEY_W-1:0] resp, input logic rdy,
                        input logic [NUM_CH-1:0] mask, input logic [CNT_W-1:0] len);
    exp_t e;
    auth_resp = resp; puf_resp = PUF; puf_ready = rdy; ch_req = mask; window_len = len;
    auth_req = 1'b1;
    if (!rdy || mask == 0 || len == 0) e.st = 2'b10;
    else if (resp != PUF) begin
      e.st = 2'b01;
      if (mfail < MAXF) mfail++;
    end else begin
      e.st = 2'b00;
      mfail = 0;
    end
    e.fc = 2'(mfail);
    sbq.push_back(e);
    @(posedge TCK); #1;
    auth_req = 1'b0;
    chk("busy", {31'd0, auth_busy}, 32'd1);
    @(posedge TCK); #1;
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {16'd0, scan_enable, window_open, locked, auth_busy, auth_done,
              auth_status, fail_count, 4'd0}, 32'd0);
    chk({tag, "_rem"}, {16'd0, remaining}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    TRST_N = 1'b0; auth_req = 1'b1; auth_resp = PUF; puf_resp = PUF; puf_ready = 1'b1;
    window_len = 16'd5; ch_req = 4'b0101; relock = 1'b0;
    scan_si = 4'hF; chain_so = 4'hF;

    // Reset with a request held high.
    repeat (3) @(posedge TCK);
    @(negedge TCK);
    chk_zero("reset");
    auth_req = 1'b0;
    TRST_N = 1'b1;
    @(posedge TCK); #1;

    // Pass: 5-cycle window on chains 0 and 2.
    do_req(PUF, 1'b1, 4'b0101, 16'd5);
    for (int i = 0; i < 8; i++) begin
      @(negedge TCK);
      chk("pass_en", {28'd0, scan_enable}, (i < 5) ? 32'h5 : 32'h0);
      chk("pass_so", {28'd0, scan_so}, (i < 5) ? 32'h5 : 32'h0);
      chk("pass_si", {28'd0, chain_si}, (i < 5) ? 32'h5 : 32'h0);
      chk("pass_rem", {16'd0, remaining}, (i < 5) ? 32'(5 - i) : 32'd0);
      chk("pass_open", {31'd0, window_open}, (i < 5) ? 32'd1 : 32'd0);
    end
    @(posedge TCK); #1;

    // Three mismatches, then timed lockout with a refused request inside it.
    repeat (3) do_req(BAD, 1'b1, 4'b0101, 16'd5);
    for (int i = 0; i < 66; i++) begin
      @(negedge TCK);
      chk("lock_lk", {31'd0, locked}, (i < LOCKC) ? 32'd1 : 32'd0);
      chk("lock_rem", {16'd0, remaining}, (i < LOCKC) ? 32'(LOCKC - i) : 32'd0);
      chk("lock_fc", {30'd0, fail_count}, (i < LOCKC) ? 32'd3 : 32'd0);
      if (i == 10) begin
        auth_req = 1'b1;
        sbq.push_back('{st: 2'b11, fc: 2'd3});
      end
      if (i == 11) auth_req = 1'b0;
    end
    mfail = 0;
    @(posedge TCK); #1;

    // Two mismatches then a pass clears the failure count.
    repeat (2) do_req(BAD, 1'b1, 4'b0011, 16'd3);
    do_req(PUF, 1'b1, 4'b0011, 16'd3);
    @(negedge TCK);
    chk("clr_open", {31'd0, window_open}, 32'd1);
    chk("clr_fc", {30'd0, fail_count}, 32'd0);
    chk("clr_en", {28'd0, scan_enable}, 32'h3);
    repeat (4) @(posedge TCK); #1;

    // Invalid requests leave the failure count alone and open nothing.
    do_req(BAD, 1'b1, 4'b0001, 16'd4);
    do_req(PUF, 1'b0, 4'b0001, 16'd4);
    chk("inv_rdy_open", {31'd0, window_open}, 32'd0);
    do_req(PUF, 1'b1, 4'b0000, 16'd4);
    chk("inv_mask_open", {31'd0, window_open}, 32'd0);
    do_req(PUF, 1'b1, 4'b0001, 16'd0);
    chk("inv_len_open", {31'd0, window_open}, 32'd0);
    chk("inv_fc", {30'd0, fail_count}, 32'd1);

    // Relock on the third cycle of a 10-cycle window.
    do_req(PUF, 1'b1, 4'b1111, 16'd10);
    repeat (3) @(negedge TCK);
    chk("rl_rem", {16'd0, remaining}, 32'd8);
    relock = 1'b1;
    @(negedge TCK);
    relock = 1'b0;
    chk("rl_en", {28'd0, scan_enable}, 32'd0);
    chk("rl_rem0", {16'd0, remaining}, 32'd0);
    chk("rl_open", {31'd0, window_open}, 32'd0);
    @(posedge TCK); #1;

    // Reset in the middle of a window.
    do_req(PUF, 1'b1, 4'b1010, 16'd10);
    repeat (3) @(negedge TCK);
    chk("mr_en_pre", {28'd0, scan_enable}, 32'hA);
    TRST_N = 1'b0;
    @(negedge TCK);
    chk_zero("midreset");
    TRST_N = 1'b1;
    mfail = 0;
    repeat (3) @(posedge TCK);

    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
